// File: rtl/control_state_machine.sv
// control_state_machine
//
// Per-instruction phase sequencer for the core. Steps through fetch request,
// fetch receive, decode, setup, execute, optional memory read and writeback,
// presenting each phase as its own one-hot strobe for the frame write-enable
// decoder. Memory waits are bounded by WAIT_LIMIT (0 = unbounded); a timeout
// parks the machine in HALTED with a sticky busError. A halt request is only
// honoured in WRITEBACK. retiredCount counts writeback cycles and wraps.
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   synchronous, active-high
//   memReady            in   fetch request accepted (FETCH_REQUEST only)
//   memDataValid        in   instruction/load data returned (wait phases only)
//   loadInstruction     in   current frame is a load (sampled in EXECUTE)
//   halt                in   stop request (sampled in WRITEBACK)
//   fetch_RequestState  out  FETCH_REQUEST phase
//   fetch_ReceiveState  out  FETCH_RECEIVE phase
//   decodeState         out  DECODE phase
//   setupState          out  SETUP phase
//   executeState        out  EXECUTE phase
//   memReadState        out  MEM_READ phase
//   writebackState      out  WRITEBACK phase
//   halted              out  HALTED state
//   busError            out  sticky memory-timeout flag
//   retiredCount        out  retired-instruction counter, COUNT_WIDTH bits
module control_state_machine #(
  parameter int COUNT_WIDTH = 32,
  parameter int WAIT_LIMIT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memReady,
  input  logic                   memDataValid,
  input  logic                   loadInstruction,
  input  logic                   halt,
  output logic                   fetch_RequestState,
  output logic                   fetch_ReceiveState,
  output logic                   decodeState,
  output logic                   setupState,
  output logic                   executeState,
  output logic                   memReadState,
  output logic                   writebackState,
  output logic                   halted,
  output logic                   busError,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  typedef enum logic [7:0] {
    S_FETCH_REQ = 8'b0000_0001,
    S_FETCH_RCV = 8'b0000_0010,
    S_DECODE    = 8'b0000_0100,
    S_SETUP     = 8'b0000_1000,
    S_EXECUTE   = 8'b0001_0000,
    S_MEM_READ  = 8'b0010_0000,
    S_WRITEBACK = 8'b0100_0000,
    S_HALTED    = 8'b1000_0000
  } state_t;

  // Last wait-counter value before the limit is hit; meaningless when the
  // timeout is disabled, which w_timeout guards against.
  localparam logic [15:0] LIMIT_M1   = 16'(WAIT_LIMIT - 1);
  localparam bit          TIMEOUT_EN = (WAIT_LIMIT != 0);

  state_t                 r_state;
  logic [15:0]            r_waitCnt;
  logic                   r_busError;
  logic [COUNT_WIDTH-1:0] r_retired;
  logic                   w_timeout;

  // Timeout fires on the WAIT_LIMIT-th consecutive empty wait cycle; a valid
  // arriving on that same cycle still wins.
  assign w_timeout = TIMEOUT_EN && !memDataValid && (r_waitCnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH_REQ;
      r_waitCnt  <= 16'd0;
      r_busError <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        S_FETCH_REQ: begin
          if (memReady) begin
            r_state   <= S_FETCH_RCV;
            r_waitCnt <= 16'd0;
          end
        end
        S_FETCH_RCV: begin
          if (memDataValid) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state    <= S_HALTED;
            r_busError <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        S_DECODE:  r_state <= S_SETUP;
        S_SETUP:   r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (loadInstruction) begin
            r_state   <= S_MEM_READ;
            r_waitCnt <= 16'd0;
          end else begin
            r_state <= S_WRITEBACK;
          end
        end
        S_MEM_READ: begin
          if (memDataValid) begin
            r_state <= S_WRITEBACK;
          end else if (w_timeout) begin
            r_state    <= S_HALTED;
            r_busError <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        S_WRITEBACK: begin
          // Retirement counts even when this writeback leads into HALTED.
          r_retired <= r_retired + COUNT_WIDTH'(1);
          r_state   <= halt ? S_HALTED : S_FETCH_REQ;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_FETCH_REQ;
      endcase
    end
  end

  // Phase strobes are the state register bits themselves.
  assign fetch_RequestState = r_state[0];
  assign fetch_ReceiveState = r_state[1];
  assign decodeState        = r_state[2];
  assign setupState         = r_state[3];
  assign executeState       = r_state[4];
  assign memReadState       = r_state[5];
  assign writebackState     = r_state[6];
  assign halted             = r_state[7];
  assign busError           = r_busError;
  assign retiredCount       = r_retired;

endmodule

// File: tb/tb_control_state_machine.sv
// Directed bench for control_state_machine. Two instances share stimulus:
// u_dut uses default parameters, u_dut4 uses COUNT_WIDTH=4, WAIT_LIMIT=4.
module tb_control_state_machine;

  logic clk = 1'b0;
  logic reset, memReady, memDataValid, loadInstruction, halt;

  logic a_req, a_rcv, a_dec, a_set, a_exe, a_mrd, a_wb, a_hlt, a_berr;
  logic [31:0] a_cnt;
  logic b_req, b_rcv, b_dec, b_set, b_exe, b_mrd, b_wb, b_hlt, b_berr;
  logic [3:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_state_machine u_dut (
    .clk(clk), .reset(reset), .memReady(memReady), .memDataValid(memDataValid),
    .loadInstruction(loadInstruction), .halt(halt),
    .fetch_RequestState(a_req), .fetch_ReceiveState(a_rcv), .decodeState(a_dec),
    .setupState(a_set), .executeState(a_exe), .memReadState(a_mrd),
    .writebackState(a_wb), .halted(a_hlt), .busError(a_berr), .retiredCount(a_cnt)
  );

  control_state_machine #(.COUNT_WIDTH(4), .WAIT_LIMIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .memReady(memReady), .memDataValid(memDataValid),
    .loadInstruction(loadInstruction), .halt(halt),
    .fetch_RequestState(b_req), .fetch_ReceiveState(b_rcv), .decodeState(b_dec),
    .setupState(b_set), .executeState(b_exe), .memReadState(b_mrd),
    .writebackState(b_wb), .halted(b_hlt), .busError(b_berr), .retiredCount(b_cnt)
  );

  logic [7:0] ph_a, ph_b;
  assign ph_a = {a_hlt, a_wb, a_mrd, a_exe, a_set, a_dec, a_rcv, a_req};
  assign ph_b = {b_hlt, b_wb, b_mrd, b_exe, b_set, b_dec, b_rcv, b_req};

  localparam logic [7:0] P_REQ = 8'h01, P_RCV = 8'h02, P_DEC = 8'h04, P_SET = 8'h08;
  localparam logic [7:0] P_EXE = 8'h10, P_MRD = 8'h20, P_WB  = 8'h40, P_HLT = 8'h80;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] seq [6];

  initial begin
    seq[0] = P_REQ; seq[1] = P_RCV; seq[2] = P_DEC;
    seq[3] = P_SET; seq[4] = P_EXE; seq[5] = P_WB;

    // Reset state
    reset = 1'b1; memReady = 1'b0; memDataValid = 1'b0;
    loadInstruction = 1'b0; halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_phase", ph_a, P_REQ);
    chk("rst_busErr", a_berr, 0);
    chk("rst_count", a_cnt, 0);
    chk("rst_phase4", ph_b, P_REQ);

    // Back-to-back non-load instructions: 6-cycle cadence
    memReady = 1'b1; memDataValid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("cycle_phase_%0d", i), ph_a, seq[i % 6]);
      tick();
    end
    chk("cycle_count3", a_cnt, 3);
    chk("cycle_phase_end", ph_a, P_REQ);

    // Load with five empty MEM_READ cycles (default limit 16)
    loadInstruction = 1'b1;
    repeat (4) tick();
    chk("ld_exe", ph_a, P_EXE);
    memDataValid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ld_mrd_wait_%0d", k), ph_a, P_MRD);
      tick();
    end
    chk("ld_mrd_6th", ph_a, P_MRD);
    memDataValid = 1'b1;
    tick();
    chk("ld_wb", ph_a, P_WB);
    chk("ld_berr", a_berr, 0);
    tick();
    chk("ld_count4", a_cnt, 4);
    chk("ld_req", ph_a, P_REQ);

    // Reset while stalled in MEM_READ
    repeat (4) tick();
    memDataValid = 1'b0;
    tick(); tick();
    chk("mid_mrd_phase", ph_a, P_MRD);
    chk("mid_mrd_count", a_cnt, 4);
    chk("dut4_ld_timeout", ph_b, P_HLT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrd_rst_phase", ph_a, P_REQ);
    chk("mrd_rst_count", a_cnt, 0);
    chk("mrd_rst_berr", a_berr, 0);
    chk("dut4_rst_berr", b_berr, 0);

    // WAIT_LIMIT=4 timeout in FETCH_RECEIVE
    loadInstruction = 1'b0;
    memDataValid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_rcv_%0d", k), ph_b, P_RCV);
      tick();
    end
    chk("to_halted", ph_b, P_HLT);
    chk("to_berr", b_berr, 1);
    for (int k = 0; k < 20; k++) begin
      memReady        = 1'($urandom_range(0, 1));
      memDataValid    = 1'($urandom_range(0, 1));
      halt            = 1'($urandom_range(0, 1));
      loadInstruction = 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("to_stay_%0d", k), {b_berr, ph_b}, {1'b1, P_HLT});
    end

    // Reset out of HALTED, then valid on the 4th receive cycle
    memReady = 1'b1; memDataValid = 1'b0; halt = 1'b0; loadInstruction = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hlt_rst_phase", ph_b, P_REQ);
    chk("hlt_rst_berr", b_berr, 0);
    chk("hlt_rst_count", b_cnt, 0);
    tick();
    repeat (3) tick();
    chk("lim_rcv_4th", ph_b, P_RCV);
    memDataValid = 1'b1;
    tick();
    chk("lim_dec", ph_b, P_DEC);
    chk("lim_berr", b_berr, 0);

    // halt in EXECUTE ignored, halt in WRITEBACK honoured
    tick(); tick();
    chk("h_exe", ph_a, P_EXE);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_wb_after_exe", ph_a, P_WB);
    tick();
    chk("h_ignored", ph_a, P_REQ);
    chk("h_count1", a_cnt, 1);
    repeat (5) tick();
    chk("h_wb2", ph_a, P_WB);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_halted", ph_a, P_HLT);
    chk("h_count2", a_cnt, 2);
    chk("h_no_berr", a_berr, 0);

    // Counter wrap with COUNT_WIDTH=4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    memReady = 1'b1; memDataValid = 1'b1; loadInstruction = 1'b0;
    repeat (90) tick();
    chk("wrap_15", b_cnt, 15);
    repeat (6) tick();
    chk("wrap_0", b_cnt, 0);
    chk("wrap_wide16", a_cnt, 16);
    chk("wrap_phase", ph_b, P_REQ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_state_machine.md
# control_state_machine

Sequencer that steps the core through its per-instruction phases: fetch request, fetch receive, decode, setup, execute, optional memory read, writeback. It drives the seven one-hot phase strobes consumed by the frame write-enable decoder directly downstream. It waits on memory handshakes, detects memory timeouts, halts on request, and counts retired instructions.

## Interface
- `COUNT_WIDTH`, 32: width of the retired-instruction counter.
- `WAIT_LIMIT`, 16: maximum cycles spent waiting for `memDataValid` in a wait phase; 0 disables the timeout; legal range 0..65535.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `memReady` input 1: memory accepts the instruction fetch request this cycle.
- `memDataValid` input 1: memory returns instruction or load data this cycle.
- `loadInstruction` input 1: decoded frame is a load; stable from SETUP through EXECUTE.
- `halt` input 1: stop request; sampled only in WRITEBACK.
- `fetch_RequestState` output 1: FETCH_REQUEST phase.
- `fetch_ReceiveState` output 1: FETCH_RECEIVE phase.
- `decodeState` output 1: DECODE phase.
- `setupState` output 1: SETUP phase.
- `executeState` output 1: EXECUTE phase.
- `memReadState` output 1: MEM_READ phase.
- `writebackState` output 1: WRITEBACK phase.
- `halted` output 1: core stopped (HALTED state).
- `busError` output 1: sticky memory-timeout flag.
- `retiredCount` output COUNT_WIDTH: instructions completed.

## Operation
- One-hot state register of eight states: the seven phases plus HALTED. Phase outputs are the register bits, with no combinational decode. At most one of the eight outputs (seven phases plus `halted`) is high.
- Transitions:
  - FETCH_REQUEST: stays while `memReady`=0; goes to FETCH_RECEIVE when it is 1.
  - FETCH_RECEIVE: stays while `memDataValid`=0; goes to DECODE when it is 1.
  - DECODE → SETUP → EXECUTE, one cycle each, unconditional.
  - EXECUTE: goes to MEM_READ if `loadInstruction`=1, else WRITEBACK.
  - MEM_READ: stays while `memDataValid`=0; goes to WRITEBACK when it is 1.
  - WRITEBACK: goes to HALTED if `halt`=1, else FETCH_REQUEST.
  - HALTED: absorbing; only `reset` leaves it.
- Wait counter (16 bits, internal):
  - Cleared on every entry to FETCH_RECEIVE or MEM_READ.
  - Increments each wait-phase cycle with `memDataValid`=0.
  - If `WAIT_LIMIT`≠0, `memDataValid`=0, and the counter equals `WAIT_LIMIT`-1, the next state is HALTED and `busError` sets.
  - A valid arriving on the `WAIT_LIMIT`-th wait cycle is accepted normally.
- `busError`: sticky until reset. It never sets on a `halt` request.
- `retiredCount`: increments by 1 on every cycle in WRITEBACK, including the one that enters HALTED. Wraps modulo 2^COUNT_WIDTH without a flag.
- `memDataValid` outside FETCH_RECEIVE/MEM_READ and `memReady` outside FETCH_REQUEST are ignored.

## Timing
- Reset values, in the cycle after `reset` is sampled high:
  - `fetch_RequestState`=1.
  - All other phase outputs = 0.
  - `halted`=0, `busError`=0, `retiredCount`=0, wait counter = 0.
- `reset` has priority over every transition in every state, including HALTED and mid-wait.
- All outputs are registered; each changes only on a `clk` edge.
- Minimum instruction latency, with `memReady` and `memDataValid` high on first opportunity:
  - Non-load: 6 cycles (REQ, RCV, DEC, SETUP, EXE, WB).
  - Load: 7 cycles (adds MEM_READ).
- `fetch_ReceiveState` stays high for every receive-wait cycle. The downstream CIR therefore rewrites each cycle, and the value captured on the `memDataValid` cycle is final. MEM_READ behaves the same way for the result register.
- `halt` high in any state other than WRITEBACK has no effect.

## Test plan
- Reset, then hold `memReady`=`memDataValid`=1 and `loadInstruction`=0 → phases cycle REQ, RCV, DEC, SETUP, EXE, WB and repeat; `retiredCount`=3 after 18 cycles; exactly one phase bit high every cycle.
- Load with `memDataValid` low for 5 cycles in MEM_READ → `memReadState` high for 6 cycles, then WRITEBACK; `busError`=0; `retiredCount` +1.
- `WAIT_LIMIT`=4, `memDataValid` never asserted in FETCH_RECEIVE → `fetch_ReceiveState` high for 4 cycles, then `halted`=1, `busError`=1; both stay set for 20 further cycles despite stimulus.
- `WAIT_LIMIT`=4, valid on the 4th receive cycle → DECODE follows; no error.
- `halt`=1 pulsed during EXECUTE only → ignored. `halt`=1 in WRITEBACK → `halted`=1 next cycle, all phase bits 0, `retiredCount` incremented.
- `reset` asserted mid-MEM_READ and again while HALTED → next cycle `fetch_RequestState`=1, `retiredCount`=0, `busError`=0. Also preload `COUNT_WIDTH`=4 and retire 16 instructions → counter wraps to 0.
